// File: rtl/sif_pkg.sv
// Shared definitions for the SIF streaming path: default beat width,
// width helpers and the derived FIFO control-state encoding.
package sif_pkg;

  localparam int DMA_WIDTH_DEF = 64;

  typedef int unsigned lvl_width_t;

  typedef enum logic [1:0] {
    ST_EMPTY,
    ST_PARTIAL,
    ST_FULL
  } ctrl_state_e;

  // Ceiling log2 that never returns 0, so a 1-entry index still gets one bit.
  function automatic int clog2_min1(input int n);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < n) r = i + 1;
    end
    return (r < 1) ? 1 : r;
  endfunction

  function automatic lvl_width_t lvl_width(input int depth);
    return lvl_width_t'(clog2_min1(depth) + 1);
  endfunction

endpackage

// File: rtl/sif_fifo_mem.sv
// DEPTH x WIDTH storage array: one synchronous write port, one asynchronous
// read port, contents deliberately left unreset.
module sif_fifo_mem #(
  parameter int WIDTH = 64,
  parameter int DEPTH = 8,
  parameter int AW    = 3
) (
  input  logic             clk,
  input  logic             we,
  input  logic [AW-1:0]    waddr,
  input  logic [WIDTH-1:0] wdata,
  input  logic [AW-1:0]    raddr,
  output logic [WIDTH-1:0] rdata
);

  logic [WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/sif_stream_fifo.sv
// Valid/ready stream FIFO with registered handshake outputs, occupancy
// watermarks, synchronous flush and a sticky source-protocol error flag.
module sif_stream_fifo
  import sif_pkg::*;
#(
  parameter int DMA_WIDTH = DMA_WIDTH_DEF,
  parameter int DEPTH     = 8,
  parameter int AF_LVL    = DEPTH - 2,
  parameter int AE_LVL    = 1
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        flush,
  input  logic                        up_vld,
  input  logic [DMA_WIDTH-1:0]        up_dat,
  output logic                        up_rdy,
  output logic                        dn_vld,
  output logic [DMA_WIDTH-1:0]        dn_dat,
  input  logic                        dn_rdy,
  output logic [lvl_width(DEPTH)-1:0] level,
  output logic                        almost_full,
  output logic                        almost_empty,
  output logic                        err_drop
);

  localparam int AW = clog2_min1(DEPTH);
  localparam int PW = AW + 1;
  localparam logic [PW-1:0] FULL_XOR = {1'b1, {AW{1'b0}}};
  localparam logic [PW-1:0] AF_THR   = PW'(AF_LVL);
  localparam logic [PW-1:0] AE_THR   = PW'(AE_LVL);

  logic [PW-1:0]        wr_ptr, rd_ptr, wr_nxt, rd_nxt;
  logic                 push, pop;
  logic                 flush_q;
  logic                 stall_q;
  logic [DMA_WIDTH-1:0] dat_q;
  logic                 protocol_err;
  logic [DMA_WIDTH-1:0] mem_rdata, head_nxt;
  ctrl_state_e          state_nxt;

  sif_fifo_mem #(
    .WIDTH(DMA_WIDTH),
    .DEPTH(DEPTH),
    .AW   (AW)
  ) u_mem (
    .clk  (clk),
    .we   (push),
    .waddr(wr_ptr[AW-1:0]),
    .wdata(up_dat),
    .raddr(rd_nxt[AW-1:0]),
    .rdata(mem_rdata)
  );

  // The head register is refilled from the entry the read pointer will point
  // at next; when that entry is being written on this same edge the array
  // still holds stale data, so the incoming beat is forwarded instead.
  always_comb begin
    push   = up_vld & up_rdy & ~flush;
    pop    = dn_vld & dn_rdy & ~flush;
    wr_nxt = wr_ptr + PW'(push);
    rd_nxt = rd_ptr + PW'(pop);
    if (flush) begin
      wr_nxt = '0;
      rd_nxt = '0;
    end

    state_nxt = ST_PARTIAL;
    if (wr_nxt == rd_nxt) begin
      state_nxt = ST_EMPTY;
    end else if ((wr_nxt ^ rd_nxt) == FULL_XOR) begin
      state_nxt = ST_FULL;
    end

    head_nxt     = (push && (rd_nxt == wr_ptr)) ? up_dat : mem_rdata;
    protocol_err = stall_q & (~up_vld | (up_dat != dat_q));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      flush_q <= 1'b0;
      up_rdy  <= 1'b0;
      dn_vld  <= 1'b0;
      dn_dat  <= '0;
    end else begin
      wr_ptr  <= wr_nxt;
      rd_ptr  <= rd_nxt;
      flush_q <= flush;
      // Ready stays low through the flush edge and the one after it.
      up_rdy  <= (state_nxt != ST_FULL) & ~flush & ~flush_q;
      dn_vld  <= (state_nxt != ST_EMPTY);
      if (state_nxt != ST_EMPTY) dn_dat <= head_nxt;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_q  <= 1'b0;
      dat_q    <= '0;
      err_drop <= 1'b0;
    end else begin
      stall_q  <= up_vld & ~up_rdy;
      dat_q    <= up_dat;
      err_drop <= err_drop | protocol_err;
    end
  end

  assign level        = wr_ptr - rd_ptr;
  assign almost_full  = (level >= AF_THR);
  assign almost_empty = (level <= AE_THR);

endmodule

// File: tb/tb_sif_stream_fifo.sv
// Self-checking bench for sif_stream_fifo (DEPTH=4, 32-bit beats) using a
// queue-based reference model plus directed scenarios.
module tb_sif_stream_fifo;

  localparam int W  = 32;
  localparam int D  = 4;
  localparam int LW = $clog2(D) + 1;
  localparam int AF = D - 2;
  localparam int AE = 1;

  logic          clk    = 1'b0;
  logic          rst_n  = 1'b1;
  logic          flush  = 1'b0;
  logic          up_vld = 1'b0;
  logic [W-1:0]  up_dat = '0;
  logic          dn_rdy = 1'b0;
  logic          up_rdy, dn_vld, almost_full, almost_empty, err_drop;
  logic [W-1:0]  dn_dat;
  logic [LW-1:0] level;

  int vectors     = 0;
  int miscompares = 0;

  logic [W-1:0] mq[$];
  bit           m_rdy, m_pflush, m_stall, m_err, last_hs;
  logic [W-1:0] m_dat;

  sif_stream_fifo #(.DMA_WIDTH(W), .DEPTH(D)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .flush       (flush),
    .up_vld      (up_vld),
    .up_dat      (up_dat),
    .up_rdy      (up_rdy),
    .dn_vld      (dn_vld),
    .dn_dat      (dn_dat),
    .dn_rdy      (dn_rdy),
    .level       (level),
    .almost_full (almost_full),
    .almost_empty(almost_empty),
    .err_drop    (err_drop)
  );

  always #5 clk = ~clk;

  task automatic model_reset();
    mq.delete();
    m_rdy    = 1'b0;
    m_pflush = 1'b0;
    m_stall  = 1'b0;
    m_err    = 1'b0;
    m_dat    = '0;
    last_hs  = 1'b0;
  endtask

  // One clock edge: the model consumes the inputs as they stood at the edge.
  task automatic step();
    bit rdy_old, pop;
    @(posedge clk);
    rdy_old = m_rdy;
    m_err   = m_err | (m_stall & (!up_vld || (up_dat != m_dat)));
    m_stall = up_vld && !rdy_old;
    m_dat   = up_dat;
    last_hs = up_vld && rdy_old;
    if (flush) begin
      mq.delete();
      m_rdy = 1'b0;
    end else begin
      pop = (mq.size() > 0) && dn_rdy;
      if (pop) void'(mq.pop_front());
      if (up_vld && rdy_old) mq.push_back(up_dat);
      m_rdy = !m_pflush && (mq.size() < D);
    end
    m_pflush = flush;
    #1;
  endtask

  task automatic test_reset();
    #2 rst_n = 1'b0;
    #1;
    vectors += 7;
    if (up_rdy !== 1'b0)       begin miscompares++; $display("[TB] FAIL reset_up_rdy: got %b expected 0", up_rdy); end
    if (dn_vld !== 1'b0)       begin miscompares++; $display("[TB] FAIL reset_dn_vld: got %b expected 0", dn_vld); end
    if (dn_dat !== '0)         begin miscompares++; $display("[TB] FAIL reset_dn_dat: got %h expected 0", dn_dat); end
    if (level !== '0)          begin miscompares++; $display("[TB] FAIL reset_level: got %0d expected 0", level); end
    if (almost_full !== 1'b0)  begin miscompares++; $display("[TB] FAIL reset_af: got %b expected 0", almost_full); end
    if (almost_empty !== 1'b1) begin miscompares++; $display("[TB] FAIL reset_ae: got %b expected 1", almost_empty); end
    if (err_drop !== 1'b0)     begin miscompares++; $display("[TB] FAIL reset_err: got %b expected 0", err_drop); end
    repeat (2) @(negedge clk);
    model_reset();
    rst_n = 1'b1;
    step();
    vectors++;
    if (up_rdy !== 1'b1) begin miscompares++; $display("[TB] FAIL release_up_rdy: got %b expected 1", up_rdy); end
  endtask

  task automatic test_fill();
    dn_rdy = 1'b0;
    for (int i = 0; i < D; i++) begin
      up_vld = 1'b1;
      up_dat = W'(32'hA0 + i);
      step();
      vectors += 4;
      if (level !== LW'(i + 1)) begin miscompares++; $display("[TB] FAIL fill_level: got %0d expected %0d", level, i + 1); end
      if (almost_full !== (i + 1 >= AF)) begin miscompares++; $display("[TB] FAIL fill_af: got %b expected %b", almost_full, (i + 1 >= AF)); end
      if (dn_vld !== 1'b1) begin miscompares++; $display("[TB] FAIL fill_dn_vld: got %b expected 1", dn_vld); end
      if (dn_dat !== 32'hA0) begin miscompares++; $display("[TB] FAIL fill_dn_dat: got %h expected a0", dn_dat); end
    end
    up_vld = 1'b0;
    vectors++;
    if (up_rdy !== 1'b0) begin miscompares++; $display("[TB] FAIL fill_full_up_rdy: got %b expected 0", up_rdy); end
  endtask

  task automatic test_full_pop();
    logic [W-1:0] exp_seq[4];
    exp_seq = '{32'hA1, 32'hA2, 32'hA3, 32'hB0};
    dn_rdy = 1'b1;
    up_vld = 1'b1;
    up_dat = 32'hB0;
    step();
    vectors += 3;
    if (level !== LW'(3))  begin miscompares++; $display("[TB] FAIL fullpop_level: got %0d expected 3", level); end
    if (up_rdy !== 1'b1)   begin miscompares++; $display("[TB] FAIL fullpop_up_rdy: got %b expected 1", up_rdy); end
    if (dn_dat !== 32'hA1) begin miscompares++; $display("[TB] FAIL fullpop_head: got %h expected a1", dn_dat); end
    dn_rdy = 1'b0;
    step();
    up_vld = 1'b0;
    vectors++;
    if (level !== LW'(4)) begin miscompares++; $display("[TB] FAIL fullpop_refill: got %0d expected 4", level); end
    dn_rdy = 1'b1;
    for (int i = 0; i < 4; i++) begin
      vectors++;
      if (dn_vld !== 1'b1 || dn_dat !== exp_seq[i]) begin
        miscompares++;
        $display("[TB] FAIL drain_order: got vld=%b dat=%h expected vld=1 dat=%h", dn_vld, dn_dat, exp_seq[i]);
      end
      step();
    end
    dn_rdy = 1'b0;
    vectors++;
    if (level !== '0) begin miscompares++; $display("[TB] FAIL drain_level: got %0d expected 0", level); end
  endtask

  task automatic test_latency();
    dn_rdy = 1'b1;
    up_vld = 1'b1;
    up_dat = 32'h55;
    step();
    up_vld = 1'b0;
    vectors += 2;
    if (dn_vld !== 1'b1)   begin miscompares++; $display("[TB] FAIL latency_vld: got %b expected 1", dn_vld); end
    if (dn_dat !== 32'h55) begin miscompares++; $display("[TB] FAIL latency_dat: got %h expected 55", dn_dat); end
    step();
    dn_rdy = 1'b0;
    vectors += 2;
    if (level !== '0)    begin miscompares++; $display("[TB] FAIL latency_level: got %0d expected 0", level); end
    if (dn_vld !== 1'b0) begin miscompares++; $display("[TB] FAIL latency_drained: got %b expected 0", dn_vld); end
  endtask

  task automatic test_back_to_back();
    dn_rdy = 1'b1;
    up_vld = 1'b1;
    for (int k = 0; k < 20; k++) begin
      up_dat = W'(k);
      step();
      vectors += 3;
      if (dn_vld !== 1'b1)  begin miscompares++; $display("[TB] FAIL b2b_vld: got %b expected 1 at beat %0d", dn_vld, k); end
      if (dn_dat !== W'(k)) begin miscompares++; $display("[TB] FAIL b2b_dat: got %0d expected %0d", dn_dat, k); end
      if (level !== LW'(1)) begin miscompares++; $display("[TB] FAIL b2b_level: got %0d expected 1", level); end
    end
    up_vld = 1'b0;
    step();
    dn_rdy = 1'b0;
    vectors++;
    if (level !== '0) begin miscompares++; $display("[TB] FAIL b2b_final_level: got %0d expected 0", level); end
  endtask

  task automatic test_flush();
    dn_rdy = 1'b0;
    for (int i = 0; i < 3; i++) begin
      up_vld = 1'b1;
      up_dat = W'(32'hC0 + i);
      step();
    end
    vectors++;
    if (level !== LW'(3)) begin miscompares++; $display("[TB] FAIL flush_pre_level: got %0d expected 3", level); end
    flush  = 1'b1;
    up_dat = 32'hF0;
    dn_rdy = 1'b1;
    step();
    flush  = 1'b0;
    up_vld = 1'b0;
    vectors += 3;
    if (level !== '0)    begin miscompares++; $display("[TB] FAIL flush_level: got %0d expected 0", level); end
    if (dn_vld !== 1'b0) begin miscompares++; $display("[TB] FAIL flush_dn_vld: got %b expected 0", dn_vld); end
    if (up_rdy !== 1'b0) begin miscompares++; $display("[TB] FAIL flush_up_rdy: got %b expected 0", up_rdy); end
    step();
    step();
    vectors++;
    if (up_rdy !== 1'b1) begin miscompares++; $display("[TB] FAIL flush_rdy_return: got %b expected 1", up_rdy); end
    dn_rdy = 1'b0;
    up_vld = 1'b1;
    up_dat = 32'h77;
    step();
    up_vld = 1'b0;
    vectors += 2;
    if (dn_dat !== 32'h77) begin miscompares++; $display("[TB] FAIL flush_discard: got %h expected 77", dn_dat); end
    if (level !== LW'(1))  begin miscompares++; $display("[TB] FAIL flush_post_level: got %0d expected 1", level); end
    dn_rdy = 1'b1;
    step();
    dn_rdy = 1'b0;
  endtask

  task automatic test_random(input int cycles);
    int n;
    for (int c = 0; c < cycles; c++) begin
      if (!up_vld || last_hs) begin
        up_vld = ($urandom_range(0, 3) != 0);
        up_dat = $urandom;
      end
      dn_rdy = ($urandom_range(0, 1) == 1);
      flush  = ($urandom_range(0, 24) == 0);
      step();
      n = mq.size();
      vectors += 6;
      if (up_rdy !== m_rdy)         begin miscompares++; $display("[TB] FAIL rnd_up_rdy: got %b expected %b", up_rdy, m_rdy); end
      if (dn_vld !== (n > 0))       begin miscompares++; $display("[TB] FAIL rnd_dn_vld: got %b expected %b", dn_vld, (n > 0)); end
      if (level !== LW'(n))         begin miscompares++; $display("[TB] FAIL rnd_level: got %0d expected %0d", level, n); end
      if (almost_full !== (n >= AF))  begin miscompares++; $display("[TB] FAIL rnd_af: got %b expected %b", almost_full, (n >= AF)); end
      if (almost_empty !== (n <= AE)) begin miscompares++; $display("[TB] FAIL rnd_ae: got %b expected %b", almost_empty, (n <= AE)); end
      if (err_drop !== m_err)       begin miscompares++; $display("[TB] FAIL rnd_err: got %b expected %b", err_drop, m_err); end
      if (n > 0) begin
        vectors++;
        if (dn_dat !== mq[0]) begin miscompares++; $display("[TB] FAIL rnd_dn_dat: got %h expected %h", dn_dat, mq[0]); end
      end
    end
    flush  = 1'b0;
    dn_rdy = 1'b1;
    for (int g = 0; g < 20 && up_vld && !last_hs; g++) step();
    up_vld = 1'b0;
    dn_rdy = 1'b0;
  endtask

  task automatic test_err_and_async_reset();
    flush = 1'b1;
    step();
    flush = 1'b0;
    step();
    step();
    dn_rdy = 1'b0;
    for (int i = 0; i < D; i++) begin
      up_vld = 1'b1;
      up_dat = W'(32'hE0 + i);
      step();
    end
    up_dat = 32'hDEAD;
    step();
    vectors += 2;
    if (level !== LW'(D))  begin miscompares++; $display("[TB] FAIL err_full_level: got %0d expected %0d", level, D); end
    if (err_drop !== 1'b0) begin miscompares++; $display("[TB] FAIL err_stall_clean: got %b expected 0", err_drop); end
    up_dat = 32'hBEEF;
    step();
    vectors++;
    if (err_drop !== 1'b1) begin miscompares++; $display("[TB] FAIL err_set: got %b expected 1", err_drop); end
    up_vld = 1'b0;
    flush  = 1'b1;
    step();
    flush  = 1'b0;
    step();
    step();
    vectors += 2;
    if (err_drop !== 1'b1) begin miscompares++; $display("[TB] FAIL err_sticky_flush: got %b expected 1", err_drop); end
    if (up_rdy !== 1'b1)   begin miscompares++; $display("[TB] FAIL err_post_flush_rdy: got %b expected 1", up_rdy); end
    dn_rdy = 1'b1;
    up_vld = 1'b1;
    up_dat = 32'h1;
    step();
    up_dat = 32'h2;
    step();
    #2 rst_n = 1'b0;
    #1;
    vectors += 6;
    if (up_rdy !== 1'b0)       begin miscompares++; $display("[TB] FAIL arst_up_rdy: got %b expected 0", up_rdy); end
    if (dn_vld !== 1'b0)       begin miscompares++; $display("[TB] FAIL arst_dn_vld: got %b expected 0", dn_vld); end
    if (dn_dat !== '0)         begin miscompares++; $display("[TB] FAIL arst_dn_dat: got %h expected 0", dn_dat); end
    if (level !== '0)          begin miscompares++; $display("[TB] FAIL arst_level: got %0d expected 0", level); end
    if (almost_empty !== 1'b1) begin miscompares++; $display("[TB] FAIL arst_ae: got %b expected 1", almost_empty); end
    if (err_drop !== 1'b0)     begin miscompares++; $display("[TB] FAIL arst_err: got %b expected 0", err_drop); end
    up_vld = 1'b0;
    dn_rdy = 1'b0;
    repeat (2) @(negedge clk);
    model_reset();
    rst_n = 1'b1;
    step();
    vectors += 2;
    if (up_rdy !== 1'b1)   begin miscompares++; $display("[TB] FAIL arst_release_rdy: got %b expected 1", up_rdy); end
    if (err_drop !== 1'b0) begin miscompares++; $display("[TB] FAIL arst_release_err: got %b expected 0", err_drop); end
  endtask

  initial begin
    model_reset();
    test_reset();
    test_fill();
    test_full_pop();
    test_latency();
    test_back_to_back();
    test_flush();
    test_random(400);
    test_err_and_async_reset();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout expected completion");
    $fatal(1, "[TB] simulation time limit exceeded");
  end

endmodule

// File: doc/sif_stream_fifo.md
Name: sif_stream_fifo

Overview:
- Parametrised valid/ready stream buffer for the SIF streaming path.
- Accepts beats on an up-stream port (block drives up_rdy) and presents them in order on a down-stream port (block drives dn_vld/dn_dat).
- Successor to the fixed-width single-register SIF link. Adds configurable width and depth, occupancy reporting, almost-full/almost-empty watermarks, a synchronous flush and a sticky protocol-error flag.
- Sits between the DMA engine and the DDR3 controller front-end.

Parameters:
- DMA_WIDTH, 64 (default taken from sif_pkg::DMA_WIDTH_DEF): data beat width in bits, >= 8.
- DEPTH, 8: number of entries. Power of two, 2..256.
- AF_LVL, DEPTH-2: almost_full asserts when level >= AF_LVL.
- AE_LVL, 1: almost_empty asserts when level <= AE_LVL.

Ports:
- clk  input  1  single clock, all logic on its posedge.
- rst_n  input  1  asynchronous, active-low reset.
- flush  input  1  synchronous clear of contents; high for one or more cycles.
- up_vld  input  1  up-stream beat valid.
- up_dat  input  DMA_WIDTH  up-stream beat data.
- up_rdy  output  1  block can accept a beat.
- dn_vld  output  1  down-stream beat valid.
- dn_dat  output  DMA_WIDTH  down-stream beat data.
- dn_rdy  input  1  consumer accepts beat.
- level  output  $clog2(DEPTH)+1  current occupancy, 0..DEPTH.
- almost_full  output  1  level >= AF_LVL.
- almost_empty  output  1  level <= AE_LVL.
- err_drop  output  1  sticky; set when up_vld is deasserted or up_dat changes while up_vld=1 and up_rdy=0 (source protocol violation).

Behaviour:
- Reset (rst_n=0, asynchronous):
  - pointers = 0, level = 0, up_rdy = 0, dn_vld = 0, dn_dat = 0, almost_full = 0, almost_empty = 1, err_drop = 0.
  - Up-stream is not accepted in the first cycle after release. up_rdy rises on the first posedge with rst_n=1.
- Transfers:
  - A push occurs on a posedge where up_vld & up_rdy.
  - A pop occurs on a posedge where dn_vld & dn_rdy.
  - Ordering is strict FIFO.
- up_rdy is a registered output = !full & !flush_q. It has no combinational path from dn_rdy.
  - When full, a pop in cycle N makes up_rdy=1 in cycle N+1.
  - Consequence: full plus pop in the same cycle does not push.
- dn_vld/dn_dat are registered outputs (first-word fall-through from a registered head).
  - Push into an empty FIFO at posedge N gives dn_vld=1 with that data after posedge N. Minimum latency is 1 cycle; there is no combinational up-to-dn path.
  - dn_dat and dn_vld stay stable while dn_vld=1 and dn_rdy=0.
- Simultaneous push and pop when not full and not empty: level is unchanged and both pointers advance.
- Pointers are $clog2(DEPTH)+1 bits wide, with an extra wrap bit.
  - full = (wr_ptr ^ rd_ptr) == {1'b1, 0...}.
  - empty = wr_ptr == rd_ptr.
  - Wrap-around is modulo 2*DEPTH with no special-casing.
- level = wr_ptr - rd_ptr, unsigned. level, almost_full and almost_empty are updated in the same cycle as the pointers.
- Flush:
  - At the posedge where flush=1, pointers and level become 0, dn_vld becomes 0 and up_rdy becomes 0.
  - Any push or pop presented in that cycle is discarded.
  - up_rdy returns 1 in the cycle after flush deasserts.
  - err_drop is not cleared by flush, only by reset.
- err_drop: the check is active only while the previous cycle had up_vld=1 and up_rdy=0.
- No internal state machine beyond the pointer/flag registers. The control states {EMPTY, PARTIAL, FULL} are derived from the pointers.

Decomposition:
- sif_pkg holds:
  - DMA_WIDTH_DEF = 64;
  - a function clog2_min1(n), which returns at least 1;
  - a typedef for the level width helper.
- Sub-module sif_fifo_mem: DEPTH x DMA_WIDTH register array with one write port (we, waddr, wdata) and one asynchronous read port (raddr, rdata). No reset on the array.
- The top level holds the pointers, flags, output registers and the error check.

Test Plan (DEPTH=4, DMA_WIDTH=32):
- Reset, then push 0xA0..0xA3 with dn_rdy=0 -> level 1,2,3,4; up_rdy=0 after 4th push; almost_full=1 from level 2; dn_dat=0xA0 held.
- From full, dn_rdy=1 and up_vld=1 for one cycle -> exactly one pop (0xA0), no push; up_rdy=1 in next cycle; level=3.
- Empty FIFO, push 0x55 at cycle N with dn_rdy=1 -> dn_vld=1, dn_dat=0x55 in cycle N+1, popped at N+1; level 0 at N+2.
- Continuous push and pop for 20 beats, incrementing data 0..19 -> output sequence 0..19 with no gaps after first beat; pointers wrap 2x without error.
- Level 3, assert flush for 1 cycle with simultaneous push -> level=0, dn_vld=0, pushed beat absent; up_rdy=1 two cycles later.
- Full FIFO, source changes up_dat while up_vld=1 -> err_drop=1 and stays 1 through flush; rst_n low mid-traffic -> all outputs return to reset values immediately, before the next clock edge.
